trigger_block_param: RTL
========================

# trigger_block_param

Parametrised trigger generator for the logic analyzer core: it watches `N_PROBES` probes of `PROBE_WIDTH` bits and asserts `trig` when the configured per-probe conditions hold.
- Conditions are combined under a selectable OR/AND mode.
- An occurrence counter adds holdoff, and an optional sticky latch holds the trigger.
- The block sits on the daisy-chained 16-bit register bus between the host interface and downstream cores. All configuration is host-writable through that bus.

## Interface
- `BASE_ADDR`, 0, first bus address of this block.
- `N_PROBES`, 4, number of probes, range 1..16.
- `PROBE_WIDTH`, 16, bits per probe, range 1..32.
- `clk` input 1: the single clock.
- `rst` input 1: reset. Synchronous, active-high.
- `probes_i` input N_PROBES*PROBE_WIDTH: packed probes, probe k at `[k*PROBE_WIDTH +: PROBE_WIDTH]`.
- `trig` output 1: registered trigger.
- `addr_i`/`wdata_i`/`rdata_i` input 16 each: upstream bus.
- `rw_i`, `valid_i` input 1 each: upstream bus (rw 1 = write).
- `addr_o`/`wdata_o`/`rdata_o` output 16 each: downstream bus, registered.
- `rw_o`, `valid_o` output 1 each: downstream bus, registered.

## Operation
- Register map (offset from `BASE_ADDR`), MAX_ADDR = 2+3*N_PROBES:
  - 0 CTRL: bit0 MODE (0 = OR, 1 = AND); bit1 STICKY. Writing bit15=1 performs CLEAR; bit15 reads 0. Other bits read 0.
  - 1 COUNT: 16-bit holdoff, read/write.
  - 2 OCC: read-only occurrence counter; writes ignored.
  - 3+3k OP_k: bits[3:0] only.
  - 4+3k ARGLO_k: arg bits [15:0].
  - 5+3k ARGHI_k: arg bits [PROBE_WIDTH-1:16]. Unimplemented bits read 0 and are write-ignored. The whole register reads 0 if PROBE_WIDTH ≤ 16.
- Ops, all comparisons unsigned:
  - 0 DISABLE; 1 RISING (cur>prev); 2 FALLING (cur<prev); 3 CHANGING (cur≠prev).
  - 4 GT arg; 5 LT; 6 GEQ; 7 LEQ; 8 EQ; 9 NEQ.
  - 10–15 behave as DISABLE.
- `prev_k` is the probe value registered every cycle. The `pv` flag clears on reset and sets one cycle later; edge ops (1–3) never match while pv=0.
- Combine:
  - OR: any enabled match.
  - AND: all enabled probes match.
  - With zero probes enabled, the combined condition `cond` = 0 in both modes.
- Occurrence/trigger, evaluated per cycle with cond=1 and no CLEAR:
  - If OCC < COUNT: OCC++ and trig stays 0.
  - Otherwise trig ← 1. OCC saturates at COUNT.
- When cond=0 and OCC ≥ COUNT:
  - Non-sticky: trig ← 0.
  - Sticky: trig holds 1 until CLEAR.
- CLEAR: OCC ← 0, trig ← 0 next cycle. CLEAR takes priority over a simultaneous cond=1.
- Config writes take effect the next cycle and do not reset OCC.
- Lowering COUNT below OCC means the next cond=1 cycle fires.
- Bus: every cycle, all `*_o` ← `*_i`.
  - If `valid_i && !rw_i` and addr is within [BASE_ADDR, BASE_ADDR+MAX_ADDR], then `rdata_o` ← register value.
  - If `valid_i && rw_i` and addr is in range, the register is written.
  - Out-of-range addresses pass through untouched.
  - `valid_i`=0 means pure passthrough, no side effects.

## Timing
- Reset, synchronous on `rst`:
  - All config registers 0, so the reset state is OR mode, non-sticky, COUNT 0, all ops DISABLE.
  - OCC 0, prev 0, pv 0, trig 0.
  - All `*_o` outputs 0.
- Bus latency: 1 cycle. Read data appears on `rdata_o` the cycle after the request.
- A write issued in cycle t is visible to the match logic in cycle t+1.
- Trigger latency: probe value in cycle t satisfying cond (with OCC ≥ COUNT) gives trig=1 in cycle t+1.
- `rst` asserted mid-operation clears state in the same edge, including any sticky trigger.

## Test plan
- Reset, then drive probe0=5 with OP0=EQ, ARG0=5: trig=1 one cycle after the match; probe0=6 gives trig=0 the next cycle.
- Edge ops: OP0=RISING, probe0 steps 3→7: trig high for exactly one cycle. Asserting reset while probe0=9 gives no match in the first cycle after reset.
- AND mode, N_PROBES=2:
  - OP0=GT 10, OP1=LT 4: trig only when probe0=11 and probe1=3.
  - Disabling probe1 leaves probe0 alone deciding.
  - Disabling both gives trig=0.
- Holdoff: COUNT=3, cond pulses on 5 separate cycles. No trig on pulses 1–3 (OCC reads 1, 2, 3); trig on pulses 4 and 5.
- Sticky plus CLEAR:
  - STICKY=1: trig stays 1 after cond drops.
  - Write CTRL=0x8002 in the same cycle as cond=1: trig=0 and OCC=0.
- Bus/width, PROBE_WIDTH=24, BASE_ADDR=0x100:
  - Write ARGHI_0=0xFFFF: reads back 0x00FF.
  - Read at 0x0FF and at 0x100+MAX_ADDR+1: `rdata_o` equals `rdata_i` delayed one cycle.

Source files
------------

// File: rtl/trigger_block_param.sv
// trigger_block_param: per-probe condition matcher with OR/AND combine, holdoff counter and sticky trigger,
// configured over a daisy-chained 16-bit register bus.
module trigger_block_param #(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          N_PROBES    = 4,
   parameter int          PROBE_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_PROBES*PROBE_WIDTH-1:0] probes_i,
   output logic                            trig,
   input  logic [15:0]                     addr_i,
   input  logic [15:0]                     wdata_i,
   input  logic [15:0]                     rdata_i,
   input  logic                            rw_i,
   input  logic                            valid_i,
   output logic [15:0]                     addr_o,
   output logic [15:0]                     wdata_o,
   output logic [15:0]                     rdata_o,
   output logic                            rw_o,
   output logic                            valid_o
);
   localparam int MAX_ADDR = 2 + 3*N_PROBES;
   // args are held 32 bits wide; bits beyond PROBE_WIDTH are forced to 0 on write
   localparam logic [31:0] MASK = PROBE_WIDTH >= 32 ? '1 : 32'((64'd1 << PROBE_WIDTH) - 64'd1);
   logic                   mode, sticky, pv, hit, wr_en, rd_en, clear, cond;
   logic [15:0]            count, occ, off, rd_val;
   logic [3:0]             op   [N_PROBES];
   logic [31:0]            arg  [N_PROBES];
   logic [PROBE_WIDTH-1:0] prev [N_PROBES];
   logic [N_PROBES-1:0]    en, m;
   assign off   = addr_i - BASE_ADDR;
   assign hit   = addr_i >= BASE_ADDR && off <= 16'(MAX_ADDR);
   assign wr_en = valid_i && rw_i && hit;
   assign rd_en = valid_i && !rw_i && hit;
   assign clear = wr_en && off == 16'd0 && wdata_i[15];
   for (genvar k = 0; k < N_PROBES; k++) begin : g_probe
      logic [31:0] c, p, a;
      assign c     = 32'(probes_i[k*PROBE_WIDTH +: PROBE_WIDTH]);
      assign p     = 32'(prev[k]);
      assign a     = arg[k];
      assign en[k] = op[k] >= 4'd1 && op[k] <= 4'd9;
      assign m[k]  = op[k] == 4'd1 ? pv && c > p :
                     op[k] == 4'd2 ? pv && c < p :
                     op[k] == 4'd3 ? pv && c != p :
                     op[k] == 4'd4 ? c > a :
                     op[k] == 4'd5 ? c < a :
                     op[k] == 4'd6 ? c >= a :
                     op[k] == 4'd7 ? c <= a :
                     op[k] == 4'd8 ? c == a :
                     op[k] == 4'd9 ? c != a : 1'b0;
   end
   assign cond = |en && (mode ? &(m | ~en) : |(m & en));
   always_comb begin
      rd_val = off == 16'd0 ? {14'd0, sticky, mode} : off == 16'd1 ? count : off == 16'd2 ? occ : 16'd0;
      for (int k = 0; k < N_PROBES; k++) begin
         if (off == 16'(3 + 3*k)) rd_val = {12'd0, op[k]};
         if (off == 16'(4 + 3*k)) rd_val = arg[k][15:0];
         if (off == 16'(5 + 3*k)) rd_val = arg[k][31:16];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mode   <= 1'b0;
         sticky <= 1'b0;
         count  <= '0;
         occ    <= '0;
         pv     <= 1'b0;
         trig   <= 1'b0;
         for (int k = 0; k < N_PROBES; k++) begin
            op[k]   <= '0;
            arg[k]  <= '0;
            prev[k] <= '0;
         end
      end else begin
         pv <= 1'b1;
         for (int k = 0; k < N_PROBES; k++) prev[k] <= probes_i[k*PROBE_WIDTH +: PROBE_WIDTH];
         if (wr_en) begin
            if (off == 16'd0) {sticky, mode} <= wdata_i[1:0];
            if (off == 16'd1) count <= wdata_i;
            for (int k = 0; k < N_PROBES; k++) begin
               if (off == 16'(3 + 3*k)) op[k] <= wdata_i[3:0];
               if (off == 16'(4 + 3*k)) arg[k][15:0] <= wdata_i & MASK[15:0];
               if (off == 16'(5 + 3*k)) arg[k][31:16] <= wdata_i & MASK[31:16];
            end
         end
         if (clear) begin
            occ  <= '0;
            trig <= 1'b0;
         end else if (cond && occ < count) begin
            occ  <= occ + 16'd1;
            trig <= sticky & trig;
         end else if (cond) trig <= 1'b1;
         else trig <= sticky & trig;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_o  <= '0;
         wdata_o <= '0;
         rdata_o <= '0;
         rw_o    <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         addr_o  <= addr_i;
         wdata_o <= wdata_i;
         rdata_o <= rd_en ? rd_val : rdata_i;
         rw_o    <= rw_i;
         valid_o <= valid_i;
      end
   end
endmodule
